// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, default reset vector, fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        TRAP
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer with
// branch/JAL/JALR redirect and misaligned-target trap.
module pc_fetch_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = riscv_pkg::DEFAULT_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_add4,
    input  logic            redirect_valid,
    input  logic            redirect_sel,
    input  logic [XLEN-1:0] redirect_pc_imm,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            if_ready,
    output logic            misalign_trap
);
    import riscv_pkg::*;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            drop, drop_nxt;
    logic            trap_pend, trap_pend_nxt;
    logic            trap_nxt;
    logic            capture;
    logic            redir;
    logic            misaligned;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;

    // JALR clears bit 0 of its target; branch/JAL targets pass through untouched.
    assign target_raw = redirect_sel ? jalr_target : redirect_pc_imm;
    assign target     = {target_raw[XLEN-1:1], target_raw[0] & ~redirect_sel};
    assign misaligned = (target[1:0] & INSTR_ALIGN_MASK) != 2'b00;
    assign redir      = redirect_valid && (state != IDLE);

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign if_valid       = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            drop          <= 1'b0;
            trap_pend     <= 1'b0;
            misalign_trap <= 1'b0;
            if_pc         <= '0;
            if_instr      <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            drop          <= drop_nxt;
            trap_pend     <= trap_pend_nxt;
            misalign_trap <= trap_nxt;
            if (capture) begin
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
            end
        end
    end

    // trap_pend remembers that a dropped in-flight response must land in TRAP.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_nxt      = drop;
        trap_pend_nxt = trap_pend;
        trap_nxt      = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (redir) begin
                    if (misaligned) begin
                        trap_nxt = 1'b1;
                        if (imem_req_ready) begin
                            drop_nxt      = 1'b1;
                            trap_pend_nxt = 1'b1;
                            state_nxt     = WAIT;
                        end else begin
                            state_nxt = TRAP;
                        end
                    end else begin
                        pc_nxt = target;
                        if (imem_req_ready) begin
                            drop_nxt      = 1'b1;
                            trap_pend_nxt = 1'b0;
                            state_nxt     = WAIT;
                        end
                    end
                end else if (imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redir) begin
                    if (misaligned) begin
                        trap_nxt = 1'b1;
                        if (imem_rsp_valid) begin
                            drop_nxt      = 1'b0;
                            trap_pend_nxt = 1'b0;
                            state_nxt     = TRAP;
                        end else begin
                            drop_nxt      = 1'b1;
                            trap_pend_nxt = 1'b1;
                        end
                    end else begin
                        pc_nxt        = target;
                        trap_pend_nxt = 1'b0;
                        if (imem_rsp_valid) begin
                            drop_nxt  = 1'b0;
                            state_nxt = FETCH;
                        end else begin
                            drop_nxt = 1'b1;
                        end
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_nxt      = 1'b0;
                        trap_pend_nxt = 1'b0;
                        state_nxt     = trap_pend ? TRAP : FETCH;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    if (misaligned) begin
                        trap_nxt  = 1'b1;
                        state_nxt = TRAP;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
                end else if (if_ready) begin
                    pc_nxt    = pc_add4;
                    state_nxt = FETCH;
                end
            end
            TRAP: begin
                if (redir) begin
                    if (misaligned) begin
                        trap_nxt = 1'b1;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
